// File: rtl/riscvsys_tbmem.sv
// rtl/riscvsys_tbmem.sv - simulation RAM and MMIO peripheral for the picorv32 native memory port
module riscvsys_tbmem #(
  parameter int unsigned MEM_BYTES    = 65536,
  parameter int unsigned STALL_MODE   = 0,
  parameter int unsigned STALL_CYCLES = 2,
  parameter logic [31:0] PRNG_SEED    = 32'd314159265,
  parameter int unsigned N_IRQ        = 4,
  parameter int unsigned IRQ_BASE     = 4,
  parameter int unsigned TIMEOUT_POW2 = 32,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] CTRL_ADDR    = 32'h2000_0000,
  parameter logic [31:0] TIMER_ADDR   = 32'h3000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_valid,
  input  logic        i_mem_instr,
  output logic        o_mem_ready,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [3:0]  i_mem_wstrb,
  output logic [31:0] o_mem_rdata,
  output logic [31:0] o_irq,
  input  logic [31:0] i_eoi,
  output logic        o_dumpon,
  output logic        o_pass,
  output logic        o_fail,
  output logic        o_timeout,
  output logic        o_oob,
  output logic [63:0] o_cycles
);
  localparam int unsigned WORDS = MEM_BYTES / 4;
  localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  logic [31:0]       mem [WORDS];
  logic [31:0]       prng, prng_next;
  logic [31:0]       reload [N_IRQ];
  logic [31:0]       count [N_IRQ];
  logic [N_IRQ-1:0]  pending, fire, tmr_sel;
  logic [AW-1:0]     word;
  logic              ram_hit, ctrl_hit, con_hit, mapped, wr;
  logic [63:0]       cycles_next;
  logic              unused;

  assign unused      = ^{i_mem_instr, prng, i_eoi};
  assign word        = i_mem_addr[AW+1:2];
  assign ram_hit     = (i_mem_addr < MEM_BYTES);
  assign ctrl_hit    = (i_mem_addr == CTRL_ADDR);
  assign con_hit     = (i_mem_addr == CONSOLE_ADDR);
  assign mapped      = ram_hit | ctrl_hit | con_hit | (|tmr_sel);
  // A write happens only on the handshake, and never while reset is held.
  assign wr          = i_mem_valid & o_mem_ready & (|i_mem_wstrb) & i_rst;
  assign cycles_next = o_cycles + 64'd1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // timer register decode and per-channel expiry
  always_comb begin
    tmr_sel = '0;
    fire    = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      tmr_sel[k] = (i_mem_addr == TIMER_ADDR + 32'(4 * k));
      fire[k]    = !(wr && tmr_sel[k]) && (reload[k] != 32'd0) && (count[k] == 32'd1);
    end
  end

  // read mux: RAM, CTRL, timer reloads; everything else reads as zero
  always_comb begin
    o_mem_rdata = 32'h0;
    if (ram_hit) o_mem_rdata = mem[word];
    else if (ctrl_hit) o_mem_rdata = {31'b0, o_dumpon};
    else for (int k = 0; k < N_IRQ; k++) if (tmr_sel[k]) o_mem_rdata = reload[k];
  end

  // RAM byte-lane stores; contents survive reset
  always_ff @(posedge i_clk) begin
    if (wr && ram_hit)
      for (int b = 0; b < 4; b++)
        if (i_mem_wstrb[b]) mem[word][8*b +: 8] <= i_mem_wdata[8*b +: 8];
  end

  // xorshift32 step
  always_comb begin
    prng_next = prng;
    prng_next = prng_next ^ (prng_next << 13);
    prng_next = prng_next ^ (prng_next >> 17);
    prng_next = prng_next ^ (prng_next << 5);
  end

  // PRNG advances every cycle out of reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) prng <= PRNG_SEED;
    else        prng <= prng_next;
  end

  generate
    if (STALL_MODE == 0) begin : g_nowait
      assign o_mem_ready = i_mem_valid;
    end else begin : g_fsm
      state_t      state, state_next;
      logic [31:0] cnt, cnt_next, load;

      assign load = (STALL_MODE == 1) ? 32'(STALL_CYCLES) : ({30'b0, prng[1:0]} + 32'd1);

      // state register and wait counter
      always_ff @(posedge i_clk) begin
        if (!i_rst) begin
          state <= IDLE;
          cnt   <= 32'd0;
        end else begin
          state <= state_next;
          cnt   <= cnt_next;
        end
      end

      // next state: cnt counts the wait cycles still to spend in WAIT
      always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
          IDLE: if (i_mem_valid) begin
            state_next = WAIT;
            cnt_next   = load;
          end
          WAIT: begin
            if (!i_mem_valid)     state_next = IDLE;
            else if (cnt <= 32'd1) state_next = ACK;
            else                  cnt_next   = cnt - 32'd1;
          end
          ACK:     state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end

      // ready is a single-cycle pulse in ACK
      always_comb begin
        o_mem_ready = (state == ACK);
      end
    end
  endgenerate

  // timer channels: reload/countdown, pending with EOI (fire wins over EOI)
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      pending <= '0;
      for (int k = 0; k < N_IRQ; k++) begin
        reload[k] <= 32'd0;
        count[k]  <= 32'd0;
      end
    end else begin
      for (int k = 0; k < N_IRQ; k++) begin
        if (wr && tmr_sel[k]) begin
          reload[k] <= merge(reload[k], i_mem_wdata, i_mem_wstrb);
          count[k]  <= merge(reload[k], i_mem_wdata, i_mem_wstrb);
        end else if (reload[k] != 32'd0) begin
          count[k] <= fire[k] ? reload[k] : count[k] - 32'd1;
        end
        pending[k] <= (pending[k] & ~i_eoi[IRQ_BASE + k]) | fire[k];
      end
    end
  end

  always_comb begin
    o_irq = '0;
    o_irq[IRQ_BASE +: N_IRQ] = pending;
  end

  // cycle counter, sticky status flags and test-control decode
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_cycles  <= 64'd0;
      o_timeout <= 1'b0;
      o_pass    <= 1'b0;
      o_fail    <= 1'b0;
      o_dumpon  <= 1'b0;
      o_oob     <= 1'b0;
    end else begin
      o_cycles  <= cycles_next;
      o_timeout <= o_timeout | cycles_next[TIMEOUT_POW2];
      if (wr && ctrl_hit) begin
        case (i_mem_wdata)
          32'hACCE_5500: o_pass   <= 1'b1;
          32'hACCE_5501: o_fail   <= 1'b1;
          32'hACCE_5502: o_dumpon <= 1'b0;
          32'hACCE_5503: o_dumpon <= 1'b1;
          default: ;
        endcase
      end
      if (wr && !mapped) o_oob <= 1'b1;
    end
  end
endmodule

// File: tb/tb_riscvsys_tbmem.sv
// tb/tb_riscvsys_tbmem.sv - directed bench: zero-wait, fixed-stall and PRNG-stall instances
module tb_riscvsys_tbmem;
  localparam logic [31:0] CON  = 32'h1000_0000;
  localparam logic [31:0] CTRL = 32'h2000_0000;
  localparam logic [31:0] TMR  = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        valid [3];
  logic        ready [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic [31:0] rdata [3];
  logic [31:0] irq   [3];
  logic [31:0] eoi   [3];
  logic        dumpon[3], pass[3], fail[3], timeout[3], oob[3];
  logic [63:0] cycles[3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscvsys_tbmem #(.MEM_BYTES(4096), .STALL_MODE(0), .TIMEOUT_POW2(8)) dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_mem_valid(valid[0]), .i_mem_instr(1'b0),
    .o_mem_ready(ready[0]), .i_mem_addr(addr[0]), .i_mem_wdata(wdata[0]),
    .i_mem_wstrb(wstrb[0]), .o_mem_rdata(rdata[0]), .o_irq(irq[0]), .i_eoi(eoi[0]),
    .o_dumpon(dumpon[0]), .o_pass(pass[0]), .o_fail(fail[0]), .o_timeout(timeout[0]),
    .o_oob(oob[0]), .o_cycles(cycles[0]));

  riscvsys_tbmem #(.MEM_BYTES(4096), .STALL_MODE(1), .STALL_CYCLES(3)) dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_mem_valid(valid[1]), .i_mem_instr(1'b0),
    .o_mem_ready(ready[1]), .i_mem_addr(addr[1]), .i_mem_wdata(wdata[1]),
    .i_mem_wstrb(wstrb[1]), .o_mem_rdata(rdata[1]), .o_irq(irq[1]), .i_eoi(eoi[1]),
    .o_dumpon(dumpon[1]), .o_pass(pass[1]), .o_fail(fail[1]), .o_timeout(timeout[1]),
    .o_oob(oob[1]), .o_cycles(cycles[1]));

  riscvsys_tbmem #(.MEM_BYTES(4096), .STALL_MODE(2)) dut2 (
    .i_clk(clk), .i_rst(rst[2]), .i_mem_valid(valid[2]), .i_mem_instr(1'b1),
    .o_mem_ready(ready[2]), .i_mem_addr(addr[2]), .i_mem_wdata(wdata[2]),
    .i_mem_wstrb(wstrb[2]), .o_mem_rdata(rdata[2]), .o_irq(irq[2]), .i_eoi(eoi[2]),
    .o_dumpon(dumpon[2]), .o_pass(pass[2]), .o_fail(fail[2]), .o_timeout(timeout[2]),
    .o_oob(oob[2]), .o_cycles(cycles[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one bus transfer; lat = cycles from valid to ready (-1 if ready never came)
  task automatic bus(input int d, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output int lat);
    @(negedge clk);
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = st;
    lat = -1; rd = 32'h0;
    for (int n = 0; n < 16; n++) begin
      #1;
      if (ready[d]) begin
        lat = n; rd = rdata[d];
        break;
      end
      @(negedge clk);
    end
    if (lat >= 0) @(posedge clk);
    #1;
    valid[d] = 1'b0; wstrb[d] = 4'h0;
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] r;
    int l;
    bus(d, a, wd, st, r, l);
    check("wr_handshake", (l >= 0), 1);
  endtask

  task automatic rd_chk(input int d, input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    int l;
    bus(d, a, 32'h0, 4'h0, r, l);
    check(tag, r, exp);
  endtask

  initial begin
    logic [31:0] r;
    int l, g;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0; valid[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0; eoi[d] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    check("rst_flags", {pass[0], fail[0], timeout[0], oob[0], dumpon[0]}, 0);
    check("rst_irq", irq[0], 0);
    check("rst_cycles", cycles[0], 0);
    check("rst_ready_m1", ready[1], 0);
    for (int d = 0; d < 3; d++) rst[d] = 1'b1;

    // zero-wait: strobed write, same-cycle ready
    wr(0, 32'h100, 32'h0, 4'hF);
    wr(0, 32'h0, 32'h0102_0304, 4'hF);
    bus(0, 32'h100, 32'h1122_3344, 4'b0101, r, l);
    check("m0_ready_same_cycle", l, 0);
    rd_chk(0, "m0_strb", 32'h100, 32'h0022_0044);
    wr(0, 32'hFFC, 32'h89AB_CDEF, 4'hF);
    rd_chk(0, "ram_last_word", 32'hFFC, 32'h89AB_CDEF);
    wr(0, CON, 32'h41, 4'h1);
    rd_chk(0, "unmapped_rd", 32'h4000_0000, 32'h0);
    check("oob_clear", oob[0], 0);

    // test-control word
    wr(0, CTRL, 32'hACCE_5503, 4'hF);
    check("dumpon_set", dumpon[0], 1);
    rd_chk(0, "ctrl_rd", CTRL, 32'h1);
    wr(0, CTRL, 32'hDEAD_BEEF, 4'hF);
    check("ctrl_ignored", {pass[0], fail[0]}, 2'b00);
    wr(0, CTRL, 32'hACCE_5500, 4'hF);
    check("pass_set", {pass[0], fail[0]}, 2'b10);
    wr(0, CTRL, 32'hACCE_5501, 4'hF);
    check("pass_fail_both", {pass[0], fail[0]}, 2'b11);
    wr(0, CTRL, 32'hACCE_5502, 4'hF);
    check("dumpon_clr", dumpon[0], 0);

    // out-of-bounds writes: flag set, aliased RAM words untouched
    wr(0, 32'h4000_0000, 32'h55, 4'hF);
    check("oob_set", oob[0], 1);
    wr(0, 32'h4000_0100, 32'hFFFF_FFFF, 4'hF);
    rd_chk(0, "oob_ram0_kept", 32'h0, 32'h0102_0304);
    rd_chk(0, "oob_ram100_kept", 32'h100, 32'h0022_0044);

    // timer 0: reload 10, fire, EOI, refire
    wr(0, TMR, 32'd10, 4'hF);
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      #1;
      check($sformatf("tmr_irq_t+%0d", j), irq[0][4], (j == 10 || j == 20));
      if (j == 10) eoi[0] = 32'h10;
      if (j == 11) eoi[0] = 32'h0;
    end
    check("tmr_other_bits", irq[0] & ~32'h10, 0);
    rd_chk(0, "tmr_reload_rd", TMR, 32'd10);
    rd_chk(0, "tmr1_reload_rd", TMR + 32'd4, 32'd0);

    // timeout at cycle 256
    g = 0;
    while (cycles[0] != 64'd255 && g < 2000) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("to_reach_255", cycles[0], 255);
    check("timeout_pre", timeout[0], 0);
    @(negedge clk);
    #1;
    check("timeout_at_256", timeout[0], 1);
    repeat (3) @(negedge clk);
    #1;
    check("timeout_sticky", timeout[0], 1);

    // reset clears flags, timers and counter but keeps RAM
    rst[0] = 1'b0;
    @(negedge clk);
    #1;
    check("rst2_flags", {pass[0], fail[0], timeout[0], oob[0], dumpon[0]}, 0);
    check("rst2_irq", irq[0], 0);
    check("rst2_cycles", cycles[0], 0);
    rst[0] = 1'b1;
    rd_chk(0, "ram_kept_rst", 32'h100, 32'h0022_0044);
    rd_chk(0, "tmr_reload_rst", TMR, 32'h0);

    // fixed stall of 3: ready on the 4th cycle, one cycle wide
    bus(1, 32'h0, 32'hCAFE_F00D, 4'hF, r, l);
    check("m1_lat_wr", l, 4);
    @(negedge clk);
    #1;
    check("m1_ready_1cyc", ready[1], 0);
    bus(1, 32'h0, 32'h0, 4'h0, r, l);
    check("m1_lat_rd", l, 4);
    check("m1_rdata", r, 32'hCAFE_F00D);

    // valid dropped during WAIT: no access
    wr(1, 32'h8, 32'h0, 4'hF);
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = 32'h8; wdata[1] = 32'h1234_5678; wstrb[1] = 4'hF;
    @(negedge clk);
    #1;
    check("abort_ready_n1", ready[1], 0);
    @(negedge clk);
    #1;
    check("abort_ready_n2", ready[1], 0);
    valid[1] = 1'b0; wstrb[1] = 4'h0;
    rd_chk(1, "abort_no_write", 32'h8, 32'h0);

    // reset in the middle of WAIT
    wr(1, TMR + 32'd4, 32'd5, 4'hF);
    wr(1, CTRL, 32'hACCE_5500, 4'hF);
    wr(1, 32'hC, 32'h0, 4'hF);
    check("m1_pass_pre", pass[1], 1);
    check("m1_irq5_pre", irq[1], 32'h20);
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = 32'hC; wdata[1] = 32'hAAAA_5555; wstrb[1] = 4'hF;
    @(negedge clk);
    rst[1] = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_ready", ready[1], 0);
    check("midrst_pass", pass[1], 0);
    check("midrst_irq", irq[1], 0);
    check("midrst_cycles", cycles[1], 0);
    rst[1] = 1'b1; valid[1] = 1'b0; wstrb[1] = 4'h0;
    rd_chk(1, "midrst_reload", TMR + 32'd4, 32'h0);
    rd_chk(1, "midrst_discard", 32'hC, 32'h0);
    repeat (12) @(negedge clk);
    #1;
    check("midrst_tmr_off", irq[1], 0);

    // PRNG stall: latency 2..5, data intact
    bus(2, 32'h10, 32'h0BAD_BEEF, 4'hF, r, l);
    check("m2_lat_wr", (l >= 2 && l <= 5), 1);
    for (int i = 0; i < 4; i++) begin
      bus(2, 32'h10, 32'h0, 4'h0, r, l);
      check($sformatf("m2_lat_rd%0d", i), (l >= 2 && l <= 5), 1);
      check($sformatf("m2_rdata%0d", i), r, 32'h0BAD_BEEF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
